// File: rtl/l0ringer_pkg.sv
// l0ringer_pkg
//   Shared sizing, types and the ring-distance helper for the L0Ringer
//   ring-sum stage. One layer is NUM_ETA x NUM_PHI towers; phi is cyclic,
//   eta is not.
package l0ringer_pkg;

  localparam int NUM_ETA    = 60;
  localparam int NUM_PHI    = 60;
  localparam int ENERGY_W   = 16;
  localparam int NUM_RINGS  = 8;

  localparam int NUM_TOWERS = NUM_ETA * NUM_PHI;
  localparam int IDX_W      = $clog2(NUM_TOWERS);
  localparam int ETA_W      = $clog2(NUM_ETA);
  localparam int PHI_W      = $clog2(NUM_PHI);
  localparam int RING_W     = (NUM_RINGS > 1) ? $clog2(NUM_RINGS) : 1;
  localparam int ACC_W      = ENERGY_W + $clog2(NUM_TOWERS);
  // One spare bit so NUM_PHI itself is representable in the wrap math.
  localparam int DIST_W     = ((ETA_W > PHI_W) ? ETA_W : PHI_W) + 1;

  typedef logic [ENERGY_W-1:0] energy_t;
  typedef logic [ACC_W-1:0]    ring_sum_t;
  typedef logic [IDX_W-1:0]    tower_idx_t;
  typedef logic [ETA_W-1:0]    eta_t;
  typedef logic [PHI_W-1:0]    phi_t;
  typedef logic [RING_W-1:0]   ring_idx_t;
  typedef logic [DIST_W-1:0]   dist_t;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Chebyshev distance between two towers; phi distance takes the short
  // way round the cylinder, eta distance is plain absolute difference.
  function automatic dist_t ring_dist(eta_t eta, phi_t phi, eta_t eta_c, phi_t phi_c);
    dist_t deta;
    dist_t dphi_raw;
    dist_t dphi_wrap;
    dist_t dphi;
    deta      = (eta >= eta_c) ? dist_t'(eta - eta_c) : dist_t'(eta_c - eta);
    dphi_raw  = (phi >= phi_c) ? dist_t'(phi - phi_c) : dist_t'(phi_c - phi);
    dphi_wrap = dist_t'(NUM_PHI) - dphi_raw;
    dphi      = (dphi_wrap < dphi_raw) ? dphi_wrap : dphi_raw;
    return (deta > dphi) ? deta : dphi;
  endfunction

endpackage

// File: rtl/tower_buffer.sv
// tower_buffer
//   Single-port NUM_TOWERS x ENERGY_W synchronous RAM holding one event.
//   Written during LOAD, read back during SCAN; read data appears one
//   cycle after the address. Contents are not reset (each event fully
//   overwrites the buffer before it is scanned).
// Ports
//   clk     clock
//   we_i    write enable
//   addr_i  tower index (eta*NUM_PHI + phi)
//   wdata_i tower energy to store
//   rdata_o registered read data for addr_i of the previous cycle
module tower_buffer
  import l0ringer_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  tower_idx_t addr_i,
  input  energy_t    wdata_i,
  output energy_t    rdata_o
);

  energy_t mem_q [NUM_TOWERS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/ring_sum_builder.sv
// ring_sum_builder
//   Buffers one calorimeter layer (eta-major tower stream), tracks the
//   hottest tower while loading, rescans the buffer summing energy per
//   square ring around the hottest tower, then emits NUM_RINGS ring sums.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_LOAD | accept towers, write buffer, track hottest, check framing
//   ST_SCAN | read buffer 0..N-1, accumulate by ring (N+1 cycles)
//   ST_EMIT | present ring sums 0..NUM_RINGS-1, one per accepted beat
//
//   Latency: the edge that accepts in_last enters SCAN; SCAN lasts N+1
//   cycles; out_valid is first high N+1 cycles after the in_last edge.
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid/in_ready        tower stream handshake
//   in_energy, in_last       tower energy, end-of-event marker
//   out_valid/out_ready      ring-sum stream handshake
//   out_ring_sum/_idx/_last  ring sum, ring number, final-ring flag
//   busy                     high in SCAN and EMIT
//   err_frame                one-cycle pulse when a malformed event is dropped
module ring_sum_builder
  import l0ringer_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  output logic      in_ready,
  input  energy_t   in_energy,
  input  logic      in_last,
  output logic      out_valid,
  input  logic      out_ready,
  output ring_sum_t out_ring_sum,
  output ring_idx_t out_ring_idx,
  output logic      out_last,
  output logic      busy,
  output logic      err_frame
);

  localparam tower_idx_t IDX_LAST    = tower_idx_t'(NUM_TOWERS - 1);
  localparam phi_t       PHI_LAST    = phi_t'(NUM_PHI - 1);
  localparam ring_idx_t  RING_LAST   = ring_idx_t'(NUM_RINGS - 1);
  localparam ring_idx_t  RING_PENULT = ring_idx_t'(NUM_RINGS - 2);

  state_e     state_q;
  tower_idx_t idx_q;
  eta_t       eta_q;
  phi_t       phi_q;
  energy_t    max_e_q;
  eta_t       max_eta_q;
  phi_t       max_phi_q;
  logic       scan_done_q;
  logic       rd_vld_q;
  eta_t       rd_eta_q;
  phi_t       rd_phi_q;
  ring_idx_t  ring_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       out_last_q;
  logic       busy_q;
  logic       err_frame_q;
  ring_sum_t  acc_q [NUM_RINGS];

  energy_t    rd_data;
  logic       accept_d;
  logic       last_tower_d;
  logic       hotter_d;
  dist_t      dist_d;
  logic       ring_hit_d;
  ring_idx_t  ring_sel_d;

  // The same counter addresses the buffer for both writing and reading.
  tower_buffer u_buf (
    .clk     (clk),
    .we_i    (accept_d),
    .addr_i  (idx_q),
    .wdata_i (in_energy),
    .rdata_o (rd_data)
  );

  assign accept_d     = in_valid && in_ready_q;
  assign last_tower_d = (idx_q == IDX_LAST);
  assign hotter_d     = (in_energy > max_e_q);  // strict: first max wins ties

  assign dist_d     = ring_dist(rd_eta_q, rd_phi_q, max_eta_q, max_phi_q);
  assign ring_hit_d = rd_vld_q && (dist_d < dist_t'(NUM_RINGS));
  assign ring_sel_d = dist_d[RING_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      eta_q       <= '0;
      phi_q       <= '0;
      max_e_q     <= '0;
      max_eta_q   <= '0;
      max_phi_q   <= '0;
      scan_done_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_eta_q    <= '0;
      rd_phi_q    <= '0;
      ring_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_frame_q <= 1'b0;
      for (int r = 0; r < NUM_RINGS; r++) begin
        acc_q[r] <= '0;
      end
    end else begin
      err_frame_q <= 1'b0;
      unique case (state_q)
        ST_LOAD: begin
          if (accept_d) begin
            if (in_last && last_tower_d) begin
              if (hotter_d) begin
                max_e_q   <= in_energy;
                max_eta_q <= eta_q;
                max_phi_q <= phi_q;
              end
              idx_q      <= '0;
              eta_q      <= '0;
              phi_q      <= '0;
              state_q    <= ST_SCAN;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else if (in_last || last_tower_d) begin
              // Early or missing in_last: drop the whole event.
              idx_q       <= '0;
              eta_q       <= '0;
              phi_q       <= '0;
              max_e_q     <= '0;
              max_eta_q   <= '0;
              max_phi_q   <= '0;
              err_frame_q <= 1'b1;
            end else begin
              if (hotter_d) begin
                max_e_q   <= in_energy;
                max_eta_q <= eta_q;
                max_phi_q <= phi_q;
              end
              idx_q <= idx_q + tower_idx_t'(1);
              if (phi_q == PHI_LAST) begin
                phi_q <= '0;
                eta_q <= eta_q + eta_t'(1);
              end else begin
                phi_q <= phi_q + phi_t'(1);
              end
            end
          end
        end

        ST_SCAN: begin
          // Address/coords issued this cycle are paired with read data next cycle.
          if (!scan_done_q) begin
            rd_vld_q <= 1'b1;
            rd_eta_q <= eta_q;
            rd_phi_q <= phi_q;
            if (last_tower_d) begin
              idx_q       <= '0;
              eta_q       <= '0;
              phi_q       <= '0;
              scan_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + tower_idx_t'(1);
              if (phi_q == PHI_LAST) begin
                phi_q <= '0;
                eta_q <= eta_q + eta_t'(1);
              end else begin
                phi_q <= phi_q + phi_t'(1);
              end
            end
          end else begin
            // Final read data is consumed this cycle.
            rd_vld_q    <= 1'b0;
            scan_done_q <= 1'b0;
            state_q     <= ST_EMIT;
            ring_q      <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (NUM_RINGS == 1);
          end
          if (ring_hit_d) begin
            acc_q[ring_sel_d] <= acc_q[ring_sel_d] + ring_sum_t'(rd_data);
          end
        end

        ST_EMIT: begin
          if (out_ready) begin
            if (ring_q == RING_LAST) begin
              for (int r = 0; r < NUM_RINGS; r++) begin
                acc_q[r] <= '0;
              end
              max_e_q     <= '0;
              max_eta_q   <= '0;
              max_phi_q   <= '0;
              ring_q      <= '0;
              state_q     <= ST_LOAD;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              ring_q     <= ring_q + ring_idx_t'(1);
              out_last_q <= (ring_q == RING_PENULT);
            end
          end
        end

        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_ring_idx = ring_q;
  assign out_ring_sum = out_valid_q ? acc_q[ring_q] : '0;
  assign busy         = busy_q;
  assign err_frame    = err_frame_q;

endmodule
